// File: rtl/mem_arb_pkg.sv
// Shared memory-arbiter definitions: FSM state encoding and default bus widths,
// also used by the cache and pipeline blocks.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;
    localparam int WDOG_W     = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_D = 2'd1;
    localparam logic [1:0] BUSY_I = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_BUSY_D = BUSY_D,
        ST_BUSY_I = BUSY_I,
        ST_FAULT  = FAULT
    } arb_state_e;

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-time watchdog: counts enabled cycles since the last clear and flags the
// cycle that completes TIMEOUT consecutive enabled cycles.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of enabled cycles already completed, so LAST marks the final one
    assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store (data first),
// with stall outputs and a sticky err flag. Optional stall counters: ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W  = ARB_ADDR_W,
    parameter int          DATA_W  = ARB_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_stall,
    input  logic              m_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,
    output logic [1:0]        dbg_state
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_if_stall,
    output logic [15:0]       perf_d_stall
`endif
);

    // Memory handshake: a strobe (m_en) is accepted on a rising edge where m_stall is low;
    // exactly one m_done pulse then completes it. Requesters hold their request until x_done.

    arb_state_e state, state_nx;

    logic              take_d;
    logic              take_i;
    logic              accept;
    logic              busy;
    logic              wdog_tc;
    logic              drop_q;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_wr;
    logic [DATA_W-1:0] mux_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_en     = 1'b0;
        take_d   = 1'b0;
        take_i   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Simultaneous load and store is a pipeline bug: refuse it without strobing
                if (d_rd && d_wr) begin
                    state_nx = ST_FAULT;
                end else if (d_rd || d_wr) begin
                    m_en   = 1'b1;
                    take_d = 1'b1;
                    if (!m_stall) state_nx = ST_BUSY_D;
                end else if (if_req) begin
                    m_en   = 1'b1;
                    take_i = 1'b1;
                    if (!m_stall) state_nx = ST_BUSY_I;
                end
            end
            ST_BUSY_D, ST_BUSY_I: begin
                if (m_done) begin
                    state_nx = ST_IDLE;
                end else if (wdog_tc) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign accept    = m_en && !m_stall;
    assign mux_addr  = take_d ? d_addr : if_addr;
    assign mux_wr    = take_d && d_wr;
    assign mux_wdata = take_d ? d_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= mux_addr;
            wr_q    <= mux_wr;
            wdata_q <= mux_wdata;
        end
    end

    // While an access is in flight the bus keeps showing the accepted command
    assign m_addr  = m_en ? mux_addr  : addr_q;
    assign m_wr    = m_en ? mux_wr    : wr_q;
    assign m_wdata = m_en ? mux_wdata : wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 1'b0;
        end else if (state != ST_BUSY_I) begin
            drop_q <= 1'b0;
        end else if (if_flush) begin
            drop_q <= 1'b1;
        end
    end

    assign d_done  = (state == ST_BUSY_D) && m_done;
    // A flush arriving in the same cycle as m_done also cancels the fetch
    assign if_done = (state == ST_BUSY_I) && m_done && !drop_q && !if_flush;
    assign d_rdata  = d_done  ? m_rdata : '0;
    assign if_rdata = if_done ? m_rdata : '0;

    assign stall_if  = if_req && !if_done;
    assign stall_mem = (d_rd || d_wr) && !d_done;
    assign err       = (state == ST_FAULT);
    assign dbg_state = state;

    assign busy = (state == ST_BUSY_D) || (state == ST_BUSY_I);

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (!busy || m_done),
        .en  (busy),
        .tc  (wdog_tc)
    );

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (stall_if && (perf_if_stall != 16'hFFFF)) perf_if_stall <= perf_if_stall + 16'd1;
            if (stall_mem && (perf_d_stall != 16'hFFFF)) perf_d_stall <= perf_d_stall + 16'd1;
        end
    end
`endif

    a_single_done: assert property (@(posedge clk) disable iff (!rst) !(if_done && d_done));
    a_strobe_idle: assert property (@(posedge clk) disable iff (!rst) m_en |-> (state == ST_IDLE));

endmodule
